// File: rtl/tag_lookup_ctrl.sv
// tag_lookup_ctrl: set-associative tag lookup front end.
// Reads every way of the indexed set, resolves hit/victim, forwards tag
// writes, and sweeps the tag arrays to zero after reset or on flush.
module tag_lookup_ctrl #(
  parameter int ID         = 0,
  parameter int data_width = 28,
  parameter int data_depth = 16,
  parameter int NUM_WAYS   = 4,
  localparam int IW = $clog2(data_depth),
  localparam int WW = $clog2(NUM_WAYS),
  localparam int TW = data_width - 2
) (
  input  logic                           clock,
  input  logic                           reset,

  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [IW-1:0]                  req_index,
  input  logic [TW-1:0]                  req_tag,

  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic                           resp_hit,
  output logic [WW-1:0]                  resp_way,
  output logic                           resp_dirty,
  output logic [WW-1:0]                  resp_victim_way,
  output logic [TW-1:0]                  resp_victim_tag,

  input  logic                           upd_valid,
  output logic                           upd_ready,
  input  logic [WW-1:0]                  upd_way,
  input  logic [IW-1:0]                  upd_index,
  input  logic [data_width-1:0]          upd_data,

  input  logic                           flush_req,
  output logic                           flush_busy,

  output logic                           tag_read_en,
  output logic [IW-1:0]                  tag_read_addr,
  input  logic [NUM_WAYS*data_width-1:0] tag_read_data,

  output logic [NUM_WAYS-1:0]            tag_write_en,
  output logic [IW-1:0]                  tag_write_addr,
  output logic [data_width-1:0]          tag_write_data
);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOOKUP,
    RESP,
    FLUSH
  } state_t;

  localparam logic [IW-1:0] LAST_SET = IW'(data_depth - 1);
  localparam int VALID_BIT = data_width - 1;
  localparam int DIRTY_BIT = data_width - 2;

  // The instance number only matters for debug output in simulation.
  logic [31:0] unused_id;
  assign unused_id = ID;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   rr_q, rr_d;
  logic            pend_q, pend_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tag_q, tag_d;

  logic            hit_q, hit_d;
  logic [WW-1:0]   way_q, way_d;
  logic            dirty_q, dirty_d;
  logic [WW-1:0]   vway_q, vway_d;
  logic [TW-1:0]   vtag_q, vtag_d;
  logic            full_q, full_d;

  logic            req_ready_q;
  logic            upd_ready_q;
  logic            flush_busy_q;
  logic            resp_valid_q;

  logic            req_fire;
  logic            upd_fire;
  logic            resp_fire;

  logic [data_width-1:0] way_entry [NUM_WAYS];

  logic            hit_c;
  logic            inv_c;
  logic [WW-1:0]   hit_way_c;
  logic [WW-1:0]   inv_way_c;
  logic [WW-1:0]   victim_c;
  logic [WW-1:0]   sel_c;

  assign req_fire  = req_valid && req_ready_q;
  assign upd_fire  = upd_valid && upd_ready_q;
  assign resp_fire = resp_valid_q && resp_ready;

  // Split the flat read bus into one entry per way.
  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_entry[w] = tag_read_data[w*data_width +: data_width];
    end
  end

  // Tag compare: lowest matching valid way wins; victim is lowest invalid way, else round-robin.
  always_comb begin
    hit_c     = 1'b0;
    inv_c     = 1'b0;
    hit_way_c = '0;
    inv_way_c = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit_c && way_entry[w][VALID_BIT] && (way_entry[w][TW-1:0] == tag_q)) begin
        hit_c     = 1'b1;
        hit_way_c = WW'(w);
      end
      if (!inv_c && !way_entry[w][VALID_BIT]) begin
        inv_c     = 1'b1;
        inv_way_c = WW'(w);
      end
    end
    victim_c = inv_c ? inv_way_c : rr_q;
    sel_c    = hit_c ? hit_way_c : victim_c;
  end

  // Next-state logic for the controller, sweep counter, pointer and response registers.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    tag_d   = tag_q;
    hit_d   = hit_q;
    way_d   = way_q;
    dirty_d = dirty_q;
    vway_d  = vway_q;
    vtag_d  = vtag_q;
    full_d  = full_q;

    if (flush_req && (state_q != IDLE)) begin
      pend_d = 1'b1;
    end

    case (state_q)
      INIT, FLUSH: begin
        cnt_d = cnt_q + IW'(1);
        if (cnt_q == LAST_SET) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      IDLE: begin
        if (req_fire) begin
          idx_d   = req_index;
          tag_d   = req_tag;
          state_d = LOOKUP;
          if (flush_req) begin
            pend_d = 1'b1;
          end
        end else if (pend_q || flush_req) begin
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = FLUSH;
        end
      end

      LOOKUP: begin
        // On a hit the victim fields are zeroed so the response is deterministic.
        hit_d   = hit_c;
        way_d   = hit_c ? hit_way_c : '0;
        dirty_d = way_entry[sel_c][DIRTY_BIT];
        vway_d  = hit_c ? '0 : victim_c;
        vtag_d  = hit_c ? '0 : way_entry[victim_c][TW-1:0];
        full_d  = !inv_c;
        state_d = RESP;
      end

      RESP: begin
        if (resp_fire) begin
          state_d = IDLE;
          if (!hit_q && full_q) begin
            rr_d = rr_q + WW'(1);
          end
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  // Single state register bank; handshake/status outputs are registered from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      cnt_q        <= '0;
      rr_q         <= '0;
      pend_q       <= 1'b0;
      idx_q        <= '0;
      tag_q        <= '0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      dirty_q      <= 1'b0;
      vway_q       <= '0;
      vtag_q       <= '0;
      full_q       <= 1'b0;
      req_ready_q  <= 1'b0;
      upd_ready_q  <= 1'b0;
      flush_busy_q <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_q         <= rr_d;
      pend_q       <= pend_d;
      idx_q        <= idx_d;
      tag_q        <= tag_d;
      hit_q        <= hit_d;
      way_q        <= way_d;
      dirty_q      <= dirty_d;
      vway_q       <= vway_d;
      vtag_q       <= vtag_d;
      full_q       <= full_d;
      req_ready_q  <= (state_d == IDLE);
      upd_ready_q  <= (state_d == IDLE) || (state_d == RESP);
      flush_busy_q <= (state_d == INIT) || (state_d == FLUSH);
      resp_valid_q <= (state_d == RESP);
    end
  end

  // Write port: the sweep owns it in INIT/FLUSH, otherwise accepted updates pass straight through.
  always_comb begin
    tag_write_en   = '0;
    tag_write_addr = '0;
    tag_write_data = '0;
    if ((state_q == INIT) || (state_q == FLUSH)) begin
      tag_write_en   = '1;
      tag_write_addr = cnt_q;
    end else if (upd_fire) begin
      tag_write_en   = {{(NUM_WAYS-1){1'b0}}, 1'b1} << upd_way;
      tag_write_addr = upd_index;
      tag_write_data = upd_data;
    end
  end

  assign tag_read_en     = (state_q == LOOKUP);
  assign tag_read_addr   = idx_q;

  assign req_ready       = req_ready_q;
  assign upd_ready       = upd_ready_q;
  assign flush_busy      = flush_busy_q;
  assign resp_valid      = resp_valid_q;
  assign resp_hit        = hit_q;
  assign resp_way        = way_q;
  assign resp_dirty      = dirty_q;
  assign resp_victim_way = vway_q;
  assign resp_victim_tag = vtag_q;

endmodule

// File: doc/tag_lookup_ctrl.md
# tag_lookup_ctrl

Lookup and maintenance controller sitting directly in front of the per-way cache tag arrays. It accepts tag lookup requests, reads all ways of the indexed set, and compares tags to produce hit/way/dirty plus a victim choice on miss. It also forwards tag updates and performs the reset-time and on-demand invalidation sweep that the tag arrays do not do themselves.

## Interface
- ID, 0, cache controller instance number (debug prints only)
- data_width, 28, tag entry width: bit [data_width-1]=valid, [data_width-2]=dirty, [data_width-3:0]=tag
- data_depth, 16, sets per way (power of two)
- NUM_WAYS, 4, ways (power of two, ≥2)

Ports (IW=$clog2(data_depth), WW=$clog2(NUM_WAYS), TW=data_width-2):
- clock  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-low reset
- req_valid / req_ready  in / out  1 / 1  lookup request handshake
- req_index  in  IW  set index
- req_tag  in  TW  tag to compare
- resp_valid / resp_ready  out / in  1 / 1  lookup response handshake
- resp_hit  out  1  tag matched a valid way
- resp_way  out  WW  hit way (0 on miss)
- resp_dirty  out  1  dirty bit of hit way, or of victim on miss
- resp_victim_way  out  WW  replacement way (valid only when resp_hit=0)
- resp_victim_tag  out  TW  tag of victim entry
- upd_valid / upd_ready  in / out  1 / 1  tag write handshake
- upd_way  in  WW;  upd_index  in  IW;  upd_data  in  data_width  full entry to write
- flush_req  in  1  pulse: invalidate all entries
- flush_busy  out  1  sweep in progress
- tag_read_en  out  1;  tag_read_addr  out  IW  shared read port to all ways
- tag_read_data  in  NUM_WAYS*data_width  way w at [w*data_width +: data_width]; combinational read
- tag_write_en  out  NUM_WAYS  per-way write enable
- tag_write_addr  out  IW;  tag_write_data  out  data_width

## Operation
- States: INIT, IDLE, LOOKUP, RESP, FLUSH.
- INIT/FLUSH: sweep counter 0..data_depth-1, one set per cycle; tag_write_en all ones, tag_write_addr=counter, tag_write_data=0. After writing data_depth-1 → IDLE. flush_busy=1; req_ready=upd_ready=0.
- IDLE: req_ready=1, upd_ready=1. Accepted request latches req_index/req_tag → LOOKUP. If flush pending (and no request accepted) → FLUSH, counter=0.
- LOOKUP: tag_read_en=1, tag_read_addr=latched index; compare each way (valid && tag equal). Hit: lowest matching way. Miss: victim = lowest-index invalid way; if all valid, victim = round-robin pointer. Results registered → RESP.
- RESP: resp_valid=1, response fields stable until resp_ready. On handshake → IDLE; if miss with all ways valid, pointer increments (wraps NUM_WAYS-1→0).
- Updates: upd_ready=1 in IDLE and RESP only. On upd_valid&&upd_ready, same cycle: tag_write_en one-hot on upd_way, addr=upd_index, data=upd_data. Update in RESP does not alter the registered response.
- flush_req outside IDLE sets a pending flag; serviced from IDLE, with priority below a request accepted that same cycle. Multiple pulses while pending coalesce.
- tag_read_en=0 and tag_write_en=0 whenever not specified above.

## Timing
- Reset (asserted, async): state=INIT, counter=0, pointer=0, flush pending=0, resp_valid=0, resp fields=0, req_ready=0, upd_ready=0, flush_busy=1. Reset mid-operation aborts any lookup/sweep; sweep restarts at 0 on release.
- INIT/FLUSH: exactly data_depth cycles of writes; req_ready=1 the cycle after the last write.
- Lookup latency: accepted at edge E0, resp_valid=1 after edge E1. Earliest next acceptance one cycle after the resp handshake. No back-to-back overlap.
- Request and update accepted in the same IDLE cycle: write commits at E0. LOOKUP reads the new value.
- resp_valid never deasserts without resp_ready.

## Test plan
- Reset release → tag_write_en=4'b1111 for 16 cycles, addr 0..15, data 0, flush_busy high throughout; then req_ready=1, flush_busy=0.
- Lookup idx 3 tag 0x123 on empty set → resp_valid after 2 edges, resp_hit=0, victim_way=0, resp_dirty=0.
- Update way 2 idx 3 data {1,0,0x123}, then lookup idx 3 tag 0x123 → hit=1, way=2, dirty=0. Same-cycle req+upd → also hit.
- Fill idx 5 ways 0..3 with tags 1..4, way 1 dirty; three misses tag 9 → victim_way 0,1,2, victim_tag 1,2,3, resp_dirty 0,1,0.
- Hold resp_ready low 5 cycles with flush_req pulse → response stable, req_ready=0; after handshake 16-cycle flush; re-lookup idx 5 tag 1 → miss, victim 0.
- Assert reset at flush counter 7 → all outputs reset values immediately; after release sweep restarts at addr 0.
